// File: rtl/leg_branch_sequencer.sv
// ---------------------------------------------------------------------------
// leg_branch_sequencer
//
// Program-counter / branch sequencer for the LEG core. It takes one decoded
// instruction (opcode byte + destination) per valid/ready handshake, together
// with the 1-bit result of the condition unit. It then decides where the next
// fetch comes from:
//   - sequential:       pc + PC_STEP (modulo 2^PC_WIDTH)
//   - taken cond. jump: dest
//   - CALL:             dest, and the return address is pushed on a hardware
//                       return-address stack
//   - RET:              the top entry of the return-address stack
// HALT_OP parks the sequencer in HALT. A CALL into a full stack, or a RET from
// an empty stack, parks it in FAULT. Only rst leaves either state.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   instr_valid  in   op / dest / cond_taken are valid this cycle
//   instr_ready  out  sequencer accepts an instruction (high only in RUN)
//   op           in   instruction opcode byte
//   dest         in   jump / call target
//   cond_taken   in   condition-unit result for op, same cycle as op
//   pc           out  current fetch address (registered)
//   redirect     out  one-cycle pulse after a non-sequential pc load
//   halted       out  sequencer is in HALT
//   fault        out  sequencer is in FAULT
//   sp           out  number of valid return-stack entries
// ---------------------------------------------------------------------------
module leg_branch_sequencer #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     PC_STEP     = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter int                     STACK_DEPTH = 4,
  parameter logic [7:0]             CALL_OP     = 8'h10,
  parameter logic [7:0]             RET_OP      = 8'h11,
  parameter logic [7:0]             HALT_OP     = 8'hFF,
  localparam int                    SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [7:0]          op,
  input  logic [PC_WIDTH-1:0] dest,
  input  logic                cond_taken,
  output logic [PC_WIDTH-1:0] pc,
  output logic                redirect,
  output logic                halted,
  output logic                fault,
  output logic [SP_W-1:0]     sp
);

  // A one-entry stack still needs a one-bit index.
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]       sp_q, sp_d;
  logic                  redirect_q, redirect_d;
  logic [PC_WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0]   stack_d [STACK_DEPTH];

  logic                  accept;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PTR_W-1:0]      push_idx;
  logic [PTR_W-1:0]      pop_idx;
  logic                  stack_full;
  logic                  stack_empty;

  assign instr_ready = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign pc          = pc_q;
  assign sp          = sp_q;
  assign redirect    = redirect_q;

  // Helper terms for decode. The sequential address is truncated to
  // PC_WIDTH, so pushed return addresses wrap exactly like pc does.
  // sp counts entries, so the free slot is at sp and the top is at sp-1;
  // both are only used when the full/empty guards permit it.
  always_comb begin
    accept      = instr_valid & instr_ready;
    pc_inc      = pc_q + PC_WIDTH'(PC_STEP);
    push_idx    = PTR_W'(sp_q);
    pop_idx     = PTR_W'(sp_q - SP_W'(1));
    stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    stack_empty = (sp_q == '0);
  end

  // Next-state decode. Everything holds and redirect drops unless an
  // instruction is accepted. Decode order matters: HALT_OP has bit 5 set,
  // so it must be tested before the conditional-jump class. A faulting
  // CALL/RET leaves pc, sp and the stack contents untouched.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    redirect_d = 1'b0;
    stack_d    = stack_q;

    if (accept) begin
      if (op == HALT_OP) begin
        state_d = ST_HALT;
      end else if (op[5]) begin
        if (cond_taken) begin
          pc_d       = dest;
          redirect_d = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end else if (op == CALL_OP) begin
        if (stack_full) begin
          state_d = ST_FAULT;
        end else begin
          stack_d[push_idx] = pc_inc;
          sp_d              = sp_q + SP_W'(1);
          pc_d              = dest;
          redirect_d        = 1'b1;
        end
      end else if (op == RET_OP) begin
        if (stack_empty) begin
          state_d = ST_FAULT;
        end else begin
          pc_d       = stack_q[pop_idx];
          sp_d       = sp_q - SP_W'(1);
          redirect_d = 1'b1;
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Control registers. Reset is asynchronous, so pc, sp, state and the
  // flags clear the moment rst rises, and any accept in flight is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      sp_q       <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      redirect_q <= redirect_d;
    end
  end

  // Return-stack storage. It is not reset: sp alone says which entries
  // are meaningful, so stale contents after reset are never read.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

endmodule

// File: tb/tb_leg_branch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_leg_branch_sequencer
//
// Self-checking bench for leg_branch_sequencer with default parameters.
// It runs three phases:
//   1. A table of single-cycle vectors with hand-computed expected outputs.
//   2. Hand-written multi-cycle corner cases: stack overflow and underflow,
//      pc wrap-around, halt, and asynchronous reset in mid-stream.
//   3. Random stimulus compared cycle by cycle against a behavioural model
//      that keeps pc as an integer and the return stack as a queue.
// ---------------------------------------------------------------------------
module tb_leg_branch_sequencer;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] op;
  logic [7:0] dest;
  logic       cond_taken;
  logic [7:0] pc;
  logic       redirect;
  logic       halted;
  logic       fault;
  logic [2:0] sp;

  int total;
  int bad;

  // Behavioural reference state
  int m_pc;
  int m_stack[$];
  bit m_halted;
  bit m_fault;
  bit m_redirect;

  typedef struct {
    logic       v;
    logic [7:0] op;
    logic [7:0] dest;
    logic       cond;
    logic [7:0] e_pc;
    logic       e_red;
    logic [2:0] e_sp;
  } vec_t;

  vec_t vecs[12];

  leg_branch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op          (op),
    .dest        (dest),
    .cond_taken  (cond_taken),
    .pc          (pc),
    .redirect    (redirect),
    .halted      (halted),
    .fault       (fault),
    .sp          (sp)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports it on a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  // Compares every output against the given expectation.
  task automatic checkAll(input string tag, input int e_pc, input bit e_red,
                          input int e_sp, input bit e_halt, input bit e_fault);
    checkOutput({tag, ".pc"},       32'(pc),          32'(e_pc));
    checkOutput({tag, ".redirect"}, 32'(redirect),    32'(e_red));
    checkOutput({tag, ".sp"},       32'(sp),          32'(e_sp));
    checkOutput({tag, ".halted"},   32'(halted),      32'(e_halt));
    checkOutput({tag, ".fault"},    32'(fault),       32'(e_fault));
    checkOutput({tag, ".ready"},    32'(instr_ready), 32'(!e_halt && !e_fault));
  endtask

  // Drives one cycle of inputs and returns 1 time unit after the clock edge
  // that samples them; valid is then dropped so nothing repeats by accident.
  task automatic applyStimulus(input logic v, input logic [7:0] o,
                               input logic [7:0] d, input logic c);
    instr_valid = v;
    op          = o;
    dest        = d;
    cond_taken  = c;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Asserts reset away from any clock edge, releases it just after an edge.
  task automatic doReset();
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pc = 0;
    m_stack.delete();
    m_halted = 1'b0;
    m_fault = 1'b0;
    m_redirect = 1'b0;
  endtask

  // Reference model: one cycle of the sequencer written from the
  // instruction rules, with pc as an integer and the stack as a queue.
  task automatic modelStep(input bit v, input int o, input int d, input bit c);
    m_redirect = 1'b0;
    if (v && !m_halted && !m_fault) begin
      if (o == 8'hFF) begin
        m_halted = 1'b1;
      end else if (o[5]) begin
        if (c) begin
          m_pc = d;
          m_redirect = 1'b1;
        end else begin
          m_pc = (m_pc + 4) % 256;
        end
      end else if (o == 8'h10) begin
        if (m_stack.size() == 4) begin
          m_fault = 1'b1;
        end else begin
          m_stack.push_back((m_pc + 4) % 256);
          m_pc = d;
          m_redirect = 1'b1;
        end
      end else if (o == 8'h11) begin
        if (m_stack.size() == 0) begin
          m_fault = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
          m_redirect = 1'b1;
        end
      end else begin
        m_pc = (m_pc + 4) % 256;
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    instr_valid = 1'b0;
    op = 8'h00;
    dest = 8'h00;
    cond_taken = 1'b0;

    // Vector table, starting from pc=0 after reset.
    vecs[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h04, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h08, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h0C, 1'b0, 3'd0};
    vecs[3]  = '{1'b1, 8'h20, 8'h40, 1'b1, 8'h40, 1'b1, 3'd0};
    vecs[4]  = '{1'b0, 8'h20, 8'h99, 1'b1, 8'h40, 1'b0, 3'd0};
    vecs[5]  = '{1'b1, 8'h21, 8'h10, 1'b0, 8'h44, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 8'h10, 8'h80, 1'b1, 8'h80, 1'b1, 3'd1};
    vecs[7]  = '{1'b1, 8'h11, 8'h00, 1'b1, 8'h48, 1'b1, 3'd0};
    vecs[8]  = '{1'b1, 8'h05, 8'h33, 1'b1, 8'h4C, 1'b0, 3'd0};
    vecs[9]  = '{1'b1, 8'h30, 8'h00, 1'b1, 8'h00, 1'b1, 3'd0};
    vecs[10] = '{1'b1, 8'h10, 8'h80, 1'b0, 8'h80, 1'b1, 3'd1};
    vecs[11] = '{1'b1, 8'h11, 8'h00, 1'b0, 8'h04, 1'b1, 3'd0};

    // Reset state
    #2;
    doReset();
    checkAll("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].v, vecs[i].op, vecs[i].dest, vecs[i].cond);
      checkAll($sformatf("vec%0d", i), int'(vecs[i].e_pc), vecs[i].e_red,
               int'(vecs[i].e_sp), 1'b0, 1'b0);
    end

    // Overflow: four CALLs fill the stack, the fifth faults with pc held.
    doReset();
    applyStimulus(1'b1, 8'h10, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
    applyStimulus(1'b1, 8'h10, 8'h30, 1'b0);
    applyStimulus(1'b1, 8'h10, 8'h40, 1'b0);
    checkAll("fill", 8'h40, 1, 4, 0, 0);
    applyStimulus(1'b1, 8'h10, 8'h50, 1'b0);
    checkAll("overflow", 8'h40, 0, 4, 0, 1);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
    checkAll("fault_hold", 8'h40, 0, 4, 0, 1);

    // Underflow: RET on an empty stack.
    doReset();
    applyStimulus(1'b1, 8'h11, 8'h00, 1'b0);
    checkAll("underflow", 0, 0, 0, 0, 1);

    // Wrap: pc 0xFC + 4 -> 0x00, and the pushed return address wraps too.
    doReset();
    applyStimulus(1'b1, 8'h20, 8'hFC, 1'b1);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
    checkAll("wrap", 8'h00, 0, 0, 0, 0);
    applyStimulus(1'b1, 8'h20, 8'hFC, 1'b1);
    applyStimulus(1'b1, 8'h10, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h11, 8'h00, 1'b0);
    checkAll("ret_wrap", 8'h00, 1, 0, 0, 0);

    // Halt, and a later valid instruction is ignored.
    doReset();
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b1);
    checkAll("halt", 8'h04, 0, 0, 1, 0);
    applyStimulus(1'b1, 8'h20, 8'h80, 1'b1);
    checkAll("halt_hold", 8'h04, 0, 0, 1, 0);

    // Asynchronous reset mid-stream with a CALL pending on the inputs.
    doReset();
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
    applyStimulus(1'b1, 8'h10, 8'h40, 1'b0);
    checkAll("pre_rst", 8'h40, 1, 2, 0, 0);
    instr_valid = 1'b1;
    op = 8'h10;
    dest = 8'h60;
    #2;
    rst = 1'b1;
    #1;
    checkAll("async_rst", 0, 0, 0, 0, 0);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll("rst_release", 0, 0, 0, 0, 0);

    // Random stimulus against the reference model, re-reset periodically.
    doReset();
    for (int n = 0; n < 600; n++) begin
      logic       rv;
      logic [7:0] ro;
      logic [7:0] rd;
      logic       rc;
      int         sel;
      if (n % 80 == 79) begin
        doReset();
        checkAll("rand_rst", m_pc, m_redirect, m_stack.size(), m_halted, m_fault);
      end
      rv  = ($urandom_range(0, 3) != 0);
      rd  = 8'($urandom);
      rc  = 1'($urandom);
      sel = $urandom_range(0, 19);
      if (sel < 6)       ro = 8'($urandom) & 8'hDF;
      else if (sel < 11) ro = 8'($urandom) | 8'h20;
      else if (sel < 15) ro = 8'h10;
      else if (sel < 19) ro = 8'h11;
      else               ro = 8'hFF;
      applyStimulus(rv, ro, rd, rc);
      modelStep(rv, int'(ro), int'(rd), rc);
      checkAll($sformatf("rand%0d", n), m_pc, m_redirect, m_stack.size(),
               m_halted, m_fault);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
